// File: rtl/vme_cmd_sequencer_pkg.sv
// ============================================================================
// vme_cmd_sequencer_pkg
//   Shared op codes, FSM encoding and VME command bit positions.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package vme_cmd_sequencer_pkg;

  localparam int c_op_w       = 2;
  localparam int c_instr_w    = 16;
  localparam int c_vme_rd_bit = 25;
  localparam int c_vme_wr_bit = 24;

  typedef enum logic [1:0] {
    OP_END      = 2'b00,
    OP_WRITE    = 2'b01,
    OP_READ     = 2'b10,
    OP_READ_CMP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_STORE    = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  function automatic logic is_read_op(input op_e op);
    return (op == OP_READ) || (op == OP_READ_CMP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vme_cmd_sequencer_sync_fifo.sv
// ============================================================================
// vme_cmd_sequencer_sync_fifo
//   Single-clock FIFO; output reads as zero while empty.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module vme_cmd_sequencer_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
  assign valid     = (r_count != '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & valid;
  assign pop_data  = valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (c_ptr_w+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (c_ptr_w+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vme_cmd_sequencer.sv
// ============================================================================
// vme_cmd_sequencer
//   Replays a programmed R/W/compare list into the VME engine registers.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module vme_cmd_sequencer
  import vme_cmd_sequencer_pkg::*;
#(
  parameter int          CMD_DEPTH = 64,
  parameter int          DATA_W    = 16,
  parameter int          RSP_DEPTH = 16,
  parameter logic [31:0] CMD_MASK  = 32'h00A80000,
  parameter int          TIMEOUT   = 1023,
  localparam int         ADDR_W    = $clog2(CMD_DEPTH),
  localparam int         CMD_W     = c_op_w + c_instr_w + DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prog_we,
  input  logic [ADDR_W-1:0]           prog_addr,
  input  logic [CMD_W-1:0]            prog_data,
  input  logic                        run,
  input  logic                        abort,
  input  logic                        loop_en,
  input  logic [ADDR_W:0]             n_cmds,
  input  logic                        vme_cmd_rd,
  input  logic                        vme_dat_wr,
  input  logic [31:0]                 vme_dat_reg_out,
  output logic                        start,
  output logic [31:0]                 vme_cmd_reg,
  output logic [31:0]                 vme_dat_reg_in,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [c_instr_w+DATA_W-1:0] rsp_data,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 err_cnt,
  output logic [15:0]                 loop_cnt,
  output logic                        timeout_err
);

  localparam int c_tmo_w = $clog2(TIMEOUT + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CMD_W-1:0]     r_mem [CMD_DEPTH];
  logic [CMD_W-1:0]     r_entry;
  logic [ADDR_W-1:0]    r_idx;
  logic                 r_run_d;
  logic [DATA_W-1:0]    r_rd_data;
  logic [c_tmo_w-1:0]   r_tmo_cnt;
  logic [15:0]          r_err_cnt;
  logic [15:0]          r_loop_cnt;
  logic                 r_timeout_err;
  logic                 r_done;

  op_e                  w_op;
  logic [c_instr_w-1:0] w_instr;
  logic [DATA_W-1:0]    w_data;
  logic                 w_run_edge;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_push;
  logic                 w_timeout;
  logic                 w_full;

  assign w_op       = op_e'(r_entry[CMD_W-1 -: c_op_w]);
  assign w_instr    = r_entry[DATA_W +: c_instr_w];
  assign w_data     = r_entry[DATA_W-1:0];
  assign w_run_edge = run & ~r_run_d;
  assign w_accept   = (r_state == ST_IDLE) & w_run_edge & ~abort;
  assign w_last     = (w_op == OP_END) || ({1'b0, r_idx} == n_cmds - (ADDR_W+1)'(1));

  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done        = r_done;
  assign err_cnt     = r_err_cnt;
  assign loop_cnt    = r_loop_cnt;
  assign timeout_err = r_timeout_err;

  // Command memory keeps its contents across reset; writes only while idle.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) r_mem[prog_addr] <= prog_data;
    if (r_state == ST_FETCH) r_entry <= r_mem[r_idx];
  end

  always_comb begin
    w_state_nxt = r_state;
    start       = 1'b0;
    w_push      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:     if (w_run_edge) w_state_nxt = (n_cmds == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:    w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (w_op == OP_END) begin
          w_state_nxt = ST_NEXT;
        end else if (vme_cmd_rd) begin
          start       = 1'b1;
          w_state_nxt = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (vme_dat_wr) begin
          w_state_nxt = is_read_op(w_op) ? ST_STORE : ST_NEXT;
        end else if (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_STORE: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT:     w_state_nxt = (w_last && !loop_en) ? ST_DONE : ST_FETCH;
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      start       = 1'b0;
      w_push      = 1'b0;
      w_timeout   = 1'b0;
    end
  end

  // Command/data registers reflect the current entry only while it is in flight.
  always_comb begin
    vme_cmd_reg    = CMD_MASK;
    vme_dat_reg_in = '0;
    if ((r_state == ST_ISSUE || r_state == ST_WAIT_RSP) && w_op != OP_END) begin
      vme_cmd_reg = CMD_MASK | {16'h0, w_instr};
      if (is_read_op(w_op)) vme_cmd_reg[c_vme_rd_bit] = 1'b1;
      else                  vme_cmd_reg[c_vme_wr_bit] = 1'b1;
      if (w_op == OP_WRITE) vme_dat_reg_in = 32'(w_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_run_d       <= 1'b0;
      r_idx         <= '0;
      r_rd_data     <= '0;
      r_tmo_cnt     <= '0;
      r_err_cnt     <= '0;
      r_loop_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run_d <= run;
      if (w_accept) begin
        r_idx         <= '0;
        r_err_cnt     <= '0;
        r_loop_cnt    <= '0;
        r_timeout_err <= 1'b0;
        r_done        <= 1'b0;
      end
      if (start)
        r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT_RSP && !vme_dat_wr)
        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
      if (r_state == ST_WAIT_RSP && vme_dat_wr)
        r_rd_data <= vme_dat_reg_out[DATA_W-1:0];
      if (w_push && w_op == OP_READ_CMP && r_rd_data != w_data && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
      if (r_state == ST_NEXT && !abort) begin
        if (w_last) begin
          r_idx <= '0;
          if (loop_en) r_loop_cnt <= r_loop_cnt + 16'd1;
        end else begin
          r_idx <= r_idx + ADDR_W'(1);
        end
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_state_nxt == ST_DONE) r_done <= 1'b1;
    end
  end

  vme_cmd_sequencer_sync_fifo #(
    .WIDTH (c_instr_w + DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({w_instr, r_rd_data}),
    .full      (w_full),
    .pop       (rsp_ready),
    .pop_data  (rsp_data),
    .valid     (rsp_valid)
  );

  if (DATA_W < 32) begin : g_unused_hi
    logic w_unused_hi;
    assign w_unused_hi = ^vme_dat_reg_out[31:DATA_W];
  end

endmodule

`default_nettype wire

// File: tb/tb_vme_cmd_sequencer.sv
// Scoreboard bench for vme_cmd_sequencer: engine model, randomized lists,
// directed boundary scenarios.
`default_nettype none

module tb_vme_cmd_sequencer;

  localparam int          DATA_W    = 16;
  localparam int          CMD_DEPTH = 64;
  localparam int          RSP_DEPTH = 16;
  localparam int          TIMEOUT   = 1023;
  localparam int          ADDR_W    = 6;
  localparam logic [31:0] MASK      = 32'h00A80000;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] instr;
    logic [15:0] data;
  } cmd_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [33:0]        prog_data;
  logic               run, abort, loop_en;
  logic [ADDR_W:0]    n_cmds;
  logic               vme_cmd_rd, vme_dat_wr;
  logic [31:0]        vme_dat_reg_out;
  logic               start;
  logic [31:0]        vme_cmd_reg, vme_dat_reg_in;
  logic               rsp_valid, rsp_ready;
  logic [31:0]        rsp_data;
  logic               busy, done;
  logic [15:0]        err_cnt, loop_cnt;
  logic               timeout_err;

  always #5 clk = ~clk;

  vme_cmd_sequencer #(
    .CMD_DEPTH (CMD_DEPTH), .DATA_W (DATA_W), .RSP_DEPTH (RSP_DEPTH),
    .CMD_MASK (MASK), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst), .prog_we (prog_we), .prog_addr (prog_addr),
    .prog_data (prog_data), .run (run), .abort (abort), .loop_en (loop_en),
    .n_cmds (n_cmds), .vme_cmd_rd (vme_cmd_rd), .vme_dat_wr (vme_dat_wr),
    .vme_dat_reg_out (vme_dat_reg_out), .start (start), .vme_cmd_reg (vme_cmd_reg),
    .vme_dat_reg_in (vme_dat_reg_in), .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_data (rsp_data), .busy (busy), .done (done), .err_cnt (err_cnt),
    .loop_cnt (loop_cnt), .timeout_err (timeout_err)
  );

  cmd_t        model_mem [CMD_DEPTH];
  cmd_t        exp_cmd_q [$];
  logic [31:0] exp_rsp_q [$];
  int          checks = 0, errors = 0;
  int          start_cnt = 0, rsp_cnt = 0, exp_err = 0;
  bit          eng_respond = 1'b1, eng_force = 1'b0;
  logic [15:0] eng_force_val = '0;
  int          eng_max_dly = 3;
  int          cmd_rd_mode = 1, rdy_mode = 1;
  logic [31:0] last_cmd = '0, last_dat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected engine-facing words, straight from the command encoding rules.
  function automatic logic [31:0] exp_cmd_word(input cmd_t c);
    return MASK | {16'h0, c.instr} | ((c.op >= 2'd2) ? 32'h0200_0000 : 32'h0100_0000);
  endfunction

  function automatic logic [31:0] exp_dat_word(input cmd_t c);
    return (c.op == 2'd1) ? {16'h0, c.data} : 32'h0;
  endfunction

  // Handshake driver for cmd_rd and rsp_ready: 0 low, 1 high, else random.
  initial begin
    vme_cmd_rd = 1'b0;
    rsp_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      vme_cmd_rd = (cmd_rd_mode == 0) ? 1'b0 : (cmd_rd_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      rsp_ready  = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Engine model: checks each issued command, answers with random data.
  initial begin
    cmd_t        c;
    logic [31:0] d;
    int          dly;
    vme_dat_wr      = 1'b0;
    vme_dat_reg_out = '0;
    forever begin
      @(negedge clk);
      if (start) begin
        start_cnt++;
        last_cmd = vme_cmd_reg;
        last_dat = vme_dat_reg_in;
        check("start_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
        if (exp_cmd_q.size() != 0) begin
          c = exp_cmd_q.pop_front();
          check("cmd_reg", 64'(vme_cmd_reg), 64'(exp_cmd_word(c)));
          check("dat_reg_in", 64'(vme_dat_reg_in), 64'(exp_dat_word(c)));
          if (eng_respond) begin
            d = $urandom;
            if (c.op == 2'd3 && $urandom_range(0, 1) == 1) d[15:0] = c.data;
            if (eng_force) d[15:0] = eng_force_val;
            if (c.op >= 2'd2) begin
              exp_rsp_q.push_back({c.instr, d[15:0]});
              if (c.op == 2'd3 && d[15:0] != c.data) exp_err++;
            end
            dly = $urandom_range(0, eng_max_dly);
            @(posedge clk);
            repeat (dly) @(posedge clk);
            #1;
            vme_dat_reg_out = d;
            vme_dat_wr      = 1'b1;
            @(posedge clk); #1;
            vme_dat_wr      = 1'b0;
            vme_dat_reg_out = $urandom;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        check("rsp_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
        if (exp_rsp_q.size() != 0) check("rsp_data", 64'(rsp_data), 64'(exp_rsp_q.pop_front()));
      end
    end
  end

  task automatic prog(input int a, input logic [1:0] op, input logic [15:0] instr, input logic [15:0] data);
    @(posedge clk); #1;
    prog_we   = 1'b1;
    prog_addr = ADDR_W'(a);
    prog_data = {op, instr, data};
    model_mem[a] = '{op: op, instr: instr, data: data};
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Reference list walk: entries in order, stopping at END or n, repeated per pass.
  task automatic model_expect(input int n, input int passes);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        if (model_mem[i].op == 2'd0) break;
        exp_cmd_q.push_back(model_mem[i]);
      end
    end
  endtask

  task automatic pulse_run();
    @(posedge clk); #1; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    rdy_mode = 1;
    @(negedge clk);
    while (rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_rsp_left"}, 64'(exp_rsp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, n, cyc;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run = 1'b0; abort = 1'b0; loop_en = 1'b0; n_cmds = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_reg", 64'(vme_cmd_reg), 64'(MASK));
    check("rst_dat_in", 64'(vme_dat_reg_in), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_loop_cnt", 64'(loop_cnt), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);

    // Single WRITE.
    prog(0, 2'd1, 16'h4100, 16'h00FF);
    n_cmds = 7'd1;
    model_expect(1, 1);
    s0 = start_cnt;
    pulse_run();
    wait_done("t1", 200);
    check("t1_starts", 64'(start_cnt - s0), 64'd1);
    check("t1_cmd", 64'(last_cmd), 64'h01A84100);
    check("t1_dat", 64'(last_dat), 64'h000000FF);
    check("t1_busy", 64'(busy), 64'd0);

    // READ_CMP with a mismatching engine value.
    prog(0, 2'd3, 16'h4200, 16'h1234);
    eng_force = 1'b1; eng_force_val = 16'h1235; exp_err = 0;
    model_expect(1, 1);
    pulse_run();
    wait_done("t2", 200);
    eng_force = 1'b0;
    check("t2_err_cnt", 64'(err_cnt), 64'd1);
    check("t2_rd_bit", 64'(last_cmd[25]), 64'd1);
    drain("t2");

    // Randomized lists with random handshakes.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        prog(i, ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
             16'($urandom), 16'($urandom));
      n_cmds = 7'(n);
      cmd_rd_mode = 2; rdy_mode = 2; eng_max_dly = 3; exp_err = 0;
      model_expect(n, 1);
      pulse_run();
      wait_done("rand", 3000);
      check("rand_err_cnt", 64'(err_cnt), 64'(exp_err));
      check("rand_timeout", 64'(timeout_err), 64'd0);
      drain("rand");
      check("rand_cmd_left", 64'(exp_cmd_q.size()), 64'd0);
    end
    cmd_rd_mode = 1;

    // Looping list aborted after the seventh issue.
    for (int i = 0; i < 3; i++) prog(i, 2'd1, 16'h6000 + 16'(i), 16'(i));
    n_cmds = 7'd3; loop_en = 1'b1; eng_max_dly = 0;
    model_expect(3, 3);
    s0 = start_cnt;
    pulse_run();
    cyc = 0;
    while (start_cnt - s0 < 7 && cyc < 500) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("t3_seven_issues", 64'(start_cnt - s0), 64'd7);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_loop_cnt", 64'(loop_cnt), 64'd2);
    check("t3_cmd_idle", 64'(vme_cmd_reg), 64'h00A80000);
    check("t3_start", 64'(start), 64'd0);
    exp_cmd_q.delete();
    loop_en = 1'b0;
    repeat (5) @(posedge clk);

    // 20 READs against a 16-deep FIFO with no pops.
    for (int i = 0; i < 20; i++) prog(i, 2'd2, 16'h5000 + 16'(i), 16'($urandom));
    n_cmds = 7'd20; rdy_mode = 0;
    model_expect(20, 1);
    s0 = start_cnt; r0 = rsp_cnt;
    pulse_run();
    repeat (150) @(negedge clk);
    check("t4_stalled_starts", 64'(start_cnt - s0), 64'd17);
    check("t4_busy", 64'(busy), 64'd1);
    check("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    rdy_mode = 0;
    repeat (20) @(posedge clk);
    rdy_mode = 1;
    wait_done("t4", 500);
    drain("t4");
    check("t4_starts", 64'(start_cnt - s0), 64'd20);
    check("t4_rsp_cnt", 64'(rsp_cnt - r0), 64'd20);

    // READ with no completion strobe.
    prog(0, 2'd2, 16'h7000, 16'h0);
    n_cmds = 7'd1; eng_respond = 1'b0;
    model_expect(1, 1);
    pulse_run();
    cyc = 0;
    while (!done && cyc < TIMEOUT + 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_done", 64'(done), 64'd1);
    check("t5_timeout_err", 64'(timeout_err), 64'd1);
    check("t5_waited", 64'(cyc >= TIMEOUT), 64'd1);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    eng_respond = 1'b1;

    // END terminates the list early.
    prog(0, 2'd1, 16'h4300, 16'h0001);
    prog(1, 2'd0, 16'h0, 16'h0);
    n_cmds = 7'd5;
    model_expect(5, 1);
    s0 = start_cnt;
    pulse_run();
    wait_done("t6", 300);
    check("t6_starts", 64'(start_cnt - s0), 64'd1);

    // Leave a failed compare in the FIFO, then reset mid-WAIT_RSP.
    rdy_mode = 0;
    prog(0, 2'd3, 16'h4400, 16'hAAAA);
    n_cmds = 7'd1; eng_force = 1'b1; eng_force_val = 16'h5555;
    model_expect(1, 1);
    pulse_run();
    wait_done("t6b", 300);
    eng_force = 1'b0;
    check("t6_fifo_held", 64'(rsp_valid), 64'd1);
    prog(0, 2'd2, 16'h4500, 16'h0);
    eng_respond = 1'b0;
    model_expect(1, 1);
    s0 = start_cnt;
    pulse_run();
    repeat (6) @(negedge clk);
    check("t6_in_flight", 64'(start_cnt - s0), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_cmd_reg", 64'(vme_cmd_reg), 64'(MASK));
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("t6_rst_timeout", 64'(timeout_err), 64'd0);
    exp_rsp_q.delete();
    eng_respond = 1'b1;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
